md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 25 ++
 rtl/md_unit_if.sv | 11 +
 rtl/md_unit.sv | 124 ++++++++++++
 tb/tb_md_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared HI/LO operation encodings and multiply/divide latencies,
// used by the control unit, the stall unit and md_unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    HL_NONE  = 4'd0,
    HL_MULT  = 4'd1,
    HL_MULTU = 4'd2,
    HL_DIV   = 4'd3,
    HL_DIVU  = 4'd4,
    HL_MFHI  = 4'd5,
    HL_MFLO  = 4'd6,
    HL_MTHI  = 4'd7,
    HL_MTLO  = 4'd8
  } hl_op_e;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  // Codes 9-15 fall outside the start range and therefore act as bubbles.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= HL_MULT) && (op <= HL_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage view of the HI/LO unit: operands and op in, stall and move-from result out.
interface md_unit_if;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  HLOp;
  logic        busy;
  logic [31:0] HLRes;

  modport master (output rs, rt, HLOp, input busy, HLRes);
  modport slave  (input rs, rt, HLOp, output busy, HLRes);
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: behavioural arithmetic latched into pending
// registers, committed to HI/LO when the latency countdown expires.
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  HLOp,
  output logic        busy,
  output logic [31:0] HLRes
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic [3:0]  r_cnt;

  logic        w_idle;
  logic        w_start;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_rs;
  logic [31:0] w_abs_rt;
  logic [31:0] w_dvsr_s;
  logic [31:0] w_dvsr_u;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_phi;
  logic [31:0] w_plo;
  logic [3:0]  w_lat;

  assign w_idle  = (r_cnt == '0);
  assign w_start = is_start_op(HLOp);

  always_comb begin
    w_prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    w_prod_u = {32'd0, rs} * {32'd0, rt};
  end

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case and
  // gives truncation toward zero with the remainder taking the dividend's sign.
  always_comb begin
    w_abs_rs = rs[31] ? -rs : rs;
    w_abs_rt = rt[31] ? -rt : rt;
    w_dvsr_s = (rt == '0) ? 32'd1 : w_abs_rt;
    w_dvsr_u = (rt == '0) ? 32'd1 : rt;
    w_mag_q  = w_abs_rs / w_dvsr_s;
    w_mag_r  = w_abs_rs % w_dvsr_s;
    w_sq     = (rs[31] ^ rt[31]) ? -w_mag_q : w_mag_q;
    w_sr     = rs[31] ? -w_mag_r : w_mag_r;
    w_uq     = rs / w_dvsr_u;
    w_ur     = rs % w_dvsr_u;
  end

  // A zero divisor pends the current HI/LO, which cannot change while counting.
  always_comb begin
    w_phi = r_phi;
    w_plo = r_plo;
    w_lat = '0;
    case (HLOp)
      HL_MULT: begin
        w_phi = w_prod_s[63:32];
        w_plo = w_prod_s[31:0];
        w_lat = MULT_LAT;
      end
      HL_MULTU: begin
        w_phi = w_prod_u[63:32];
        w_plo = w_prod_u[31:0];
        w_lat = MULT_LAT;
      end
      HL_DIV: begin
        w_phi = (rt == '0) ? r_hi : w_sr;
        w_plo = (rt == '0) ? r_lo : w_sq;
        w_lat = DIV_LAT;
      end
      HL_DIVU: begin
        w_phi = (rt == '0) ? r_hi : w_ur;
        w_plo = (rt == '0) ? r_lo : w_uq;
        w_lat = DIV_LAT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_phi <= '0;
      r_plo <= '0;
      r_cnt <= '0;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_start) begin
      r_phi <= w_phi;
      r_plo <= w_plo;
      r_cnt <= w_lat;
    end else if (HLOp == HL_MTHI) begin
      r_hi <= rs;
    end else if (HLOp == HL_MTLO) begin
      r_lo <= rs;
    end
  end

  assign busy = !w_idle || w_start;

  always_comb begin
    HLRes = '0;
    if (HLOp == HL_MFHI) HLRes = r_hi;
    else if (HLOp == HL_MFLO) HLRes = r_lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios then random ops,
// compared against an arithmetic reference of the HI/LO semantics.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  md_unit_if hl ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .rs    (hl.rs),
    .rt    (hl.rt),
    .HLOp  (hl.HLOp),
    .busy  (hl.busy),
    .HLRes (hl.HLRes)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: committed HI/LO, cycles until the outstanding result lands,
  // the result itself and whether it is allowed to land at all.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  int          m_left;
  bit          m_commit;
  int unsigned busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_res_hi = '0; m_res_lo = '0;
    m_left = 0; m_commit = 1'b0;
  endtask

  // Work out what an accepted start op produces, straight from the arithmetic.
  task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          as, bs, p, q, r;
    longint unsigned au, bu, pu;
    as = longint'($signed(a)); bs = longint'($signed(b));
    au = {32'd0, a};           bu = {32'd0, b};
    m_commit = 1'b1;
    if (op == 4'd1 || op == 4'd2) begin
      m_left = 5;
      if (op == 4'd1) begin p = as * bs; m_res_hi = p[63:32]; m_res_lo = p[31:0]; end
      else begin pu = au * bu; m_res_hi = pu[63:32]; m_res_lo = pu[31:0]; end
    end else begin
      m_left = 10;
      if (b == 0) m_commit = 1'b0;
      else if (op == 4'd3) begin
        q = as / bs; r = as % bs; m_res_hi = r[31:0]; m_res_lo = q[31:0];
      end else begin
        q = longint'(au / bu); r = longint'(au % bu);
        m_res_hi = r[31:0]; m_res_lo = q[31:0];
      end
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res);
    logic        exp_busy;
    logic [31:0] exp_res;
    @(negedge clk);
    hl.HLOp = op; hl.rs = a; hl.rt = b;
    #1;
    exp_busy = (m_left != 0) || (op >= 4'd1 && op <= 4'd4);
    exp_res  = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    chk("busy", {31'd0, hl.busy}, {31'd0, exp_busy});
    chk("HLRes", hl.HLRes, exp_res);
    if (hl.busy === 1'b1) busy_seen++;
    res = hl.HLRes;
    @(posedge clk);
    if (m_left != 0) begin
      m_left--;
      if (m_left == 0 && m_commit) begin m_hi = m_res_hi; m_lo = m_res_lo; end
    end else if (op >= 4'd1 && op <= 4'd4) model_issue(op, a, b);
    else if (op == 4'd7) m_hi = a;
    else if (op == 4'd8) m_lo = a;
  endtask

  task automatic idle(input int unsigned n);
    logic [31:0] d;
    for (int unsigned i = 0; i < n; i++) step(4'd0, $urandom, $urandom, d);
  endtask

  // Reset asserted mid-cycle: the clear must be visible before any clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    hl.HLOp = HL_MFHI;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, hl.busy}, 32'd0);
    chk("rst_hi", hl.HLRes, 32'd0);
    hl.HLOp = HL_MFLO;
    #1 chk("rst_lo", hl.HLRes, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] r, old_lo, old_hi;
  logic [3:0]  op;
  logic [31:0] a, b;

  initial begin
    reset = 1'b1;
    hl.HLOp = HL_NONE; hl.rs = '0; hl.rt = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_busy", {31'd0, hl.busy}, 32'd0);
    reset = 1'b0;

    // Signed multiply, busy for exactly 6 cycles
    busy_seen = 0;
    step(HL_MULT, 32'hFFFFFFFE, 32'd3, r);
    idle(6);
    chk("mult_busy_cycles", busy_seen, 32'd6);
    step(HL_MFHI, '0, '0, r); chk("mult_hi", r, 32'hFFFFFFFF);
    step(HL_MFLO, '0, '0, r); chk("mult_lo", r, 32'hFFFFFFFA);

    // Unsigned multiply; LO reads stay old during the countdown
    step(HL_MULTU, 32'hFFFFFFFF, 32'd2, r);
    step(HL_MFLO, '0, '0, r); chk("multu_old_lo", r, 32'hFFFFFFFA);
    idle(4);
    step(HL_MFHI, '0, '0, r); chk("multu_hi", r, 32'd1);
    step(HL_MFLO, '0, '0, r); chk("multu_lo", r, 32'hFFFFFFFE);

    // Signed divide, busy for 11 cycles
    busy_seen = 0;
    step(HL_DIV, 32'hFFFFFFF9, 32'd2, r);
    idle(11);
    chk("div_busy_cycles", busy_seen, 32'd11);
    step(HL_MFLO, '0, '0, r); chk("div_lo", r, 32'hFFFFFFFD);
    step(HL_MFHI, '0, '0, r); chk("div_hi", r, 32'hFFFFFFFF);

    // Divide by zero keeps HI/LO
    step(HL_MTLO, 32'h12345678, '0, r);
    step(HL_DIVU, 32'd5, 32'd0, r);
    idle(10);
    step(HL_MFLO, '0, '0, r); chk("divz_lo", r, 32'h12345678);
    step(HL_MFHI, '0, '0, r); chk("divz_hi", r, 32'hFFFFFFFF);

    // Overflow divide
    step(HL_DIV, 32'h80000000, 32'hFFFFFFFF, r);
    idle(10);
    step(HL_MFLO, '0, '0, r); chk("ovf_lo", r, 32'h80000000);
    step(HL_MFHI, '0, '0, r); chk("ovf_hi", r, 32'd0);

    // Reset during a divide countdown aborts the result
    step(HL_DIV, 32'd100, 32'd7, r);
    idle(3);
    pulse_reset();
    idle(12);
    step(HL_MFHI, '0, '0, r); chk("abort_hi", r, 32'd0);
    step(HL_MFLO, '0, '0, r); chk("abort_lo", r, 32'd0);

    // MTHI and a second start op during a multiply are both ignored
    step(HL_MULT, 32'h00012345, 32'hFFFF0001, r);
    step(HL_MTHI, 32'hAAAA0000, '0, r);
    step(HL_DIV, 32'd9, 32'd3, r);
    idle(3);
    step(HL_MFHI, '0, '0, r); chk("mthi_ignored", r, 32'hFFFFFFFE);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op = ($urandom_range(0, 1) != 0) ? HL_MFHI : HL_MFLO;
        1: op = 4'($urandom_range(1, 4));
        default: op = 4'($urandom_range(0, 15));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(op, a, b, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
